// File: rtl/multimode_ff_reg.sv
// Multimode register: hold, load, toggle, JK, up/down count, shift.
// Registered terminal-count pulse on counter wrap only.
module multimode_ff_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_TOG  = 3'b010,
    M_JK   = 3'b011,
    M_UP   = 3'b100,
    M_DN   = 3'b101,
    M_SHL  = 3'b110,
    M_SHR  = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_next;
  logic             wrap;
  mode_t            op;

  assign op = mode_t'(mode);

  // Next state for the selected operation and its wrap flag.
  always_comb begin
    q_next = q;
    wrap   = 1'b0;
    unique case (op)
      M_HOLD: q_next = q;
      M_LOAD: q_next = d;
      M_TOG:  q_next = q ^ d;
      M_JK:   q_next = (q & ~k) | (~q & d);
      M_UP: begin
        q_next = q + ONE;
        wrap   = &q;
      end
      M_DN: begin
        q_next = q - ONE;
        wrap   = ~|q;
      end
      M_SHL:  q_next = {q[WIDTH-2:0], sin};
      M_SHR:  q_next = {sin, q[WIDTH-1:1]};
    endcase
  end

  // State register: reset, then clear, then enable gate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= RESET_VAL;
      tc <= 1'b0;
    end else if (clr) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (!en) begin
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= wrap;
    end
  end

endmodule
